fpu_addsub_arbiter: RTL and testbench
=====================================

FPU_ADDSUB_ARBITER -- requirements
Module: fpu_addsub_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles allowed for the shared unit to return done.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have, per requester i in {0,1}, port req_i  input  1  operation request, held until ack_i.
REQ-005 SHALL have, per requester, port dataa_i  input  32  IEEE-754 single-precision operand A.
REQ-006 SHALL have, per requester, port datab_i  input  32  IEEE-754 single-precision operand B.
REQ-007 SHALL have, per requester, port op_i  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-008 SHALL have, per requester, port ack_i  output  1  one-cycle pulse marking that result_i/err_i are valid.
REQ-009 SHALL have, per requester, port result_i  output  32  registered result, held until that requester's next ack.
REQ-010 SHALL have, per requester, port err_i  output  1  timeout flag, valid with ack_i.
REQ-011 SHALL have port unit_enable  output  1  enable to the shared add/sub unit.
REQ-012 SHALL have ports unit_dataa and unit_datab  output  32 each  operands to the shared unit.
REQ-013 SHALL have port unit_result  input  32  result from the shared unit.
REQ-014 SHALL have port unit_done  input  1  done from the shared unit; this signal is sticky and is never cleared by the unit.

Function
REQ-015 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-016 SHALL, in IDLE with any req_i high, latch the granted requester's operands and op, then move to ISSUE.
REQ-017 SHALL arbitrate round-robin: when both requests are high, grant the requester not served last; after reset, requester 0 has priority.
REQ-018 SHALL drive unit_dataa = A and unit_datab = B when op=0, and unit_datab = {~B[31], B[30:0]} when op=1.
REQ-019 SHALL hold operands stable from ISSUE until leaving WAIT, and drive them to 0 otherwise.
REQ-020 SHALL assert unit_enable in ISSUE and WAIT only, and move ISSUE->WAIT unconditionally after 1 cycle.
REQ-021 SHALL, in WAIT, ignore unit_done on the first WAIT cycle, because sticky done from a previous operation is stale.
REQ-022 SHALL, in WAIT, capture unit_result on the first subsequent cycle with unit_done=1 and go to RESP with err=0.
REQ-023 SHALL count WAIT cycles with a counter of width $clog2(TIMEOUT+1); when the count reaches TIMEOUT without done, it SHALL go to RESP with err=1 and result 32'h7FC00000 (quiet NaN).
REQ-024 SHALL, in RESP, pulse the granted requester's ack for 1 cycle, update its result/err, update the last-served pointer, and return to IDLE.
REQ-025 SHALL give minimum latency of 4 cycles from req sampled to ack (IDLE, ISSUE, WAIT x2, then RESP ack).
REQ-026 SHALL never pulse ack to a requester that was not granted, and never pulse both acks in the same cycle.
REQ-027 SHALL ignore a req that drops mid-operation; the operation completes and ack is still issued.
REQ-028 SHALL allow a requester holding req high across its ack to be re-arbitrated in the following IDLE cycle.

Reset
REQ-029 SHALL, on reset assertion (asynchronous), force state IDLE, ack_i=0, result_i=0, err_i=0, unit_enable=0, unit operands 0, counter 0, and last-served pointer = 1.
REQ-030 SHALL abandon an in-flight operation on reset mid-operation, with no ack produced afterwards for it.

Structure
REQ-031 SHALL place the FSM state encoding, OP_ADD/OP_SUB constants and the QNAN constant (32'h7FC00000) in shared package fpu_ctrl_pkg.
REQ-032 SHALL factor out the round-robin grant logic as sub-module rr_arb2 (inputs req[1:0], last; output grant[1:0]).
REQ-033 SHALL contain no floating-point arithmetic; sign flipping is the only operand manipulation.

Verification
REQ-034 SHALL cover: req_0 with A=32'h40400000 (3.0), B=32'h3F800000 (1.0), op=1 -> unit_datab=32'hBF800000, and result_0=32'h40000000 returned with ack_0 after a model done.
REQ-035 SHALL cover: req_0 and req_1 asserted in the same cycle after reset -> requester 0 served first, then requester 1, with acks in consecutive operations.
REQ-036 SHALL cover: unit_done stuck high from a prior operation -> no capture on the first WAIT cycle; capture on the second.
REQ-037 SHALL cover: unit_done held low with TIMEOUT=16 -> ack with err=1 and result=32'h7FC00000 after 16 WAIT cycles.
REQ-038 SHALL cover: reset asserted while in WAIT -> all outputs 0 immediately (asynchronously) and no later ack.
REQ-039 SHALL cover: req_1 held continuously while req_0 toggles -> the grant pattern alternates 0,1,0,1.

Source files
------------

// File: rtl/fpu_ctrl_pkg.sv
// Shared control definitions for the FP add/sub arbiter: FSM states, op codes,
// the timeout result value and the operand-B sign handling.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Subtraction is issued to the unit as an addition with B's sign inverted.
    function automatic logic [31:0] operand_b(input logic [31:0] b, input logic op);
        logic [31:0] r;
        case (op)
            OP_ADD:  r = b;
            OP_SUB:  r = {~b[31], b[30:0]};
            default: r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: with both requests active, the requester that
// was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Arbitrates two requesters onto one shared FP add/sub unit, issuing operands,
// waiting on the unit's sticky done (with timeout) and returning results.
module fpu_addsub_arbiter
    import fpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic        req_1,
    input  logic [31:0] dataa_0,
    input  logic [31:0] datab_0,
    input  logic        op_0,
    input  logic [31:0] dataa_1,
    input  logic [31:0] datab_1,
    input  logic        op_1,
    output logic        ack_0,
    output logic        ack_1,
    output logic [31:0] result_0,
    output logic [31:0] result_1,
    output logic        err_0,
    output logic        err_1,
    output logic        unit_enable,
    output logic [31:0] unit_dataa,
    output logic [31:0] unit_datab,
    input  logic [31:0] unit_result,
    input  logic        unit_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       grant;
    logic             sel_p0;
    logic             last;
    logic [31:0]      a_p0;
    logic [31:0]      b_p0;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             take;
    logic             done_ok;
    logic             timed_out;
    logic             finish;
    logic [31:0]      res_nxt;

    rr_arb2 u_arb (
        .req   ({req_1, req_0}),
        .last  (last),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Done is sticky, so the first WAIT cycle may still show the previous
    // operation's done; only later WAIT cycles may complete the operation.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        busy      = 1'b0;
        done_ok   = 1'b0;
        timed_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    take      = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy      = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy      = 1'b1;
                done_ok   = (cnt != '0) && unit_done;
                timed_out = !done_ok && (cnt == CNT_LAST);
                if (done_ok || timed_out) state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign finish      = done_ok || timed_out;
    assign res_nxt     = done_ok ? unit_result : QNAN;
    assign unit_enable = busy;
    assign unit_dataa  = busy ? a_p0 : '0;
    assign unit_datab  = busy ? b_p0 : '0;

    // p0: operands of the granted requester, captured when leaving IDLE
    always_ff @(posedge clk) begin
        if (take) begin
            a_p0 <= grant[1] ? dataa_1 : dataa_0;
            b_p0 <= grant[1] ? operand_b(datab_1, op_1) : operand_b(datab_0, op_0);
        end
    end

    // Response registers load on the WAIT->RESP edge so ack is high during RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_p0   <= 1'b0;
            last     <= 1'b1;
            cnt      <= '0;
            ack_0    <= 1'b0;
            ack_1    <= 1'b0;
            result_0 <= '0;
            result_1 <= '0;
            err_0    <= 1'b0;
            err_1    <= 1'b0;
        end else begin
            ack_0 <= 1'b0;
            ack_1 <= 1'b0;
            cnt   <= (state == ST_WAIT) ? cnt + 1'b1 : '0;
            if (take) sel_p0 <= grant[1];
            if (finish) begin
                if (sel_p0) begin
                    ack_1    <= 1'b1;
                    result_1 <= res_nxt;
                    err_1    <= timed_out;
                end else begin
                    ack_0    <= 1'b1;
                    result_0 <= res_nxt;
                    err_0    <= timed_out;
                end
            end
            if (state == ST_RESP) last <= sel_p0;
        end
    end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter: a shared-unit model, a scoreboard of expected
// acks, a vector table and hand-written arbitration/reset sequences.
module tb_fpu_addsub_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_0, req_1;
    logic [31:0] dataa_0, datab_0, dataa_1, datab_1;
    logic        op_0, op_1;
    logic        ack_0, ack_1;
    logic [31:0] result_0, result_1;
    logic        err_0, err_1;
    logic        unit_enable;
    logic [31:0] unit_dataa, unit_datab;
    logic [31:0] unit_result;
    logic        unit_done;

    always #5 clk = ~clk;

    fpu_addsub_arbiter #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_0       (req_0),
        .req_1       (req_1),
        .dataa_0     (dataa_0),
        .datab_0     (datab_0),
        .op_0        (op_0),
        .dataa_1     (dataa_1),
        .datab_1     (datab_1),
        .op_1        (op_1),
        .ack_0       (ack_0),
        .ack_1       (ack_1),
        .result_0    (result_0),
        .result_1    (result_1),
        .err_0       (err_0),
        .err_1       (err_1),
        .unit_enable (unit_enable),
        .unit_dataa  (unit_dataa),
        .unit_datab  (unit_datab),
        .unit_result (unit_result),
        .unit_done   (unit_done)
    );

    typedef struct {
        logic        who;
        logic [31:0] res;
        logic        err;
    } exp_t;

    typedef struct {
        logic        who;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] exp_datab;
        logic [31:0] ures;
        int          dly;
        logic        keep;
        logic [31:0] exp_res;
        logic        exp_err;
        int          lat;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vecs[7];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] hold_res[2];
    logic        hold_err[2];

    int          um_dly;
    logic [31:0] um_res;
    logic        um_keep;
    int          um_cnt;
    logic        um_armed;
    logic        en_prev;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mon_step();
        exp_t e;
        logic who;
        if (reset) begin
            hold_res[0] = '0; hold_res[1] = '0;
            hold_err[0] = 1'b0; hold_err[1] = 1'b0;
            return;
        end
        if (ack_0 || ack_1) begin
            chk32("single_ack", {31'd0, ack_0 & ack_1}, 32'd0);
            who = ack_1;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack_%0d, expected none", who);
            end else begin
                e = sbq.pop_front();
                chk32("ack_who", {31'd0, who}, {31'd0, e.who});
                chk32("result", who ? result_1 : result_0, e.res);
                chk32("err", {31'd0, who ? err_1 : err_0}, {31'd0, e.err});
                hold_res[who] = e.res;
                hold_err[who] = e.err;
            end
            chk32("other_result_held", who ? result_0 : result_1, hold_res[!who]);
        end
    endtask

    // Shared unit model: sticky done, raised um_dly cycles after issue.
    task automatic unit_step();
        if (reset) begin
            um_armed = 1'b0;
            en_prev  = 1'b0;
            return;
        end
        if (unit_enable && !en_prev) begin
            if (!um_keep) unit_done = 1'b0;
            um_cnt   = 0;
            um_armed = 1'b1;
        end
        if (um_armed) begin
            if (um_cnt == um_dly) begin
                unit_done   = 1'b1;
                unit_result = um_res;
                um_armed    = 1'b0;
            end
            um_cnt++;
        end
        en_prev = unit_enable;
    endtask

    task automatic tick();
        @(negedge clk);
        mon_step();
        unit_step();
    endtask

    task automatic wait_ack(input string name, input int limit,
                            output int lat, output logic who, output bit ok);
        lat = 0; who = 1'b0; ok = 1'b0;
        while (!ok && lat < limit) begin
            tick();
            lat++;
            if (ack_0 || ack_1) begin
                ok  = 1'b1;
                who = ack_1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: got no ack, expected one within %0d cycles", name, limit);
        end
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        bit seen, issued;
        um_dly = v.dly; um_res = v.ures; um_keep = v.keep;
        if (v.who) begin
            req_1 = 1'b1; dataa_1 = v.a; datab_1 = v.b; op_1 = v.op;
        end else begin
            req_0 = 1'b1; dataa_0 = v.a; datab_0 = v.b; op_0 = v.op;
        end
        sbq.push_back('{v.who, v.exp_res, v.exp_err});
        lat = 0; seen = 1'b0; issued = 1'b0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (unit_enable && !issued) begin
                issued = 1'b1;
                chk32("unit_dataa", unit_dataa, v.a);
                chk32("unit_datab", unit_datab, v.exp_datab);
            end
            if (ack_0 || ack_1) seen = 1'b1;
        end
        if (!seen || !issued) begin
            checks++;
            errors++;
            $display("FAIL op_done: got issued=%0d ack=%0d, expected both 1", issued, seen);
        end
        chk32("latency", 32'(lat), 32'(v.lat));
        if (v.who) req_1 = 1'b0;
        else       req_0 = 1'b0;
    endtask

    initial begin
        int   lat, acks, t;
        logic who;
        bit   ok;

        vecs[0] = '{1'b0, 32'h40400000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40000000, 0, 1'b0, 32'h40000000, 1'b0, 4};
        vecs[1] = '{1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000, 0, 1'b0, 32'h40400000, 1'b0, 4};
        vecs[2] = '{1'b0, 32'hC0000000, 32'hC0800000, 1'b1, 32'h40800000, 32'h40000000, 1, 1'b1, 32'h40000000, 1'b0, 4};
        vecs[3] = '{1'b1, 32'h00000000, 32'hBF800000, 1'b1, 32'h3F800000, 32'h3F800000, 5, 1'b0, 32'h3F800000, 1'b0, 7};
        vecs[4] = '{1'b0, 32'h41200000, 32'h40A00000, 1'b0, 32'h40A00000, 32'h41700000, -1, 1'b0, 32'h7FC00000, 1'b1, 18};
        vecs[5] = '{1'b1, 32'h7F800000, 32'h00000000, 1'b0, 32'h00000000, 32'h7F800000, 2, 1'b0, 32'h7F800000, 1'b0, 4};
        vecs[6] = '{1'b0, 32'h3FC00000, 32'h80000000, 1'b1, 32'h00000000, 32'h3FC00000, 3, 1'b0, 32'h3FC00000, 1'b0, 5};

        reset = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0; op_0 = 1'b0; op_1 = 1'b0;
        dataa_0 = '0; datab_0 = '0; dataa_1 = '0; datab_1 = '0;
        unit_result = '0; unit_done = 1'b0;
        um_dly = 0; um_res = '0; um_keep = 1'b0; um_cnt = 0; um_armed = 1'b0; en_prev = 1'b0;
        hold_res[0] = '0; hold_res[1] = '0; hold_err[0] = 1'b0; hold_err[1] = 1'b0;

        repeat (3) tick();
        chk32("rst_ack", {30'd0, ack_1, ack_0}, 32'd0);
        chk32("rst_result_0", result_0, 32'd0);
        chk32("rst_result_1", result_1, 32'd0);
        chk32("rst_err", {30'd0, err_1, err_0}, 32'd0);
        chk32("rst_enable", {31'd0, unit_enable}, 32'd0);
        chk32("rst_operands", unit_dataa | unit_datab, 32'd0);
        reset = 1'b0;
        tick();

        // Simultaneous requests right after reset: 0 first, then 1.
        um_dly = 0; um_keep = 1'b0; um_res = 32'h3F800000;
        req_0 = 1'b1; dataa_0 = 32'h3F000000; datab_0 = 32'h3F000000; op_0 = 1'b0;
        req_1 = 1'b1; dataa_1 = 32'h40000000; datab_1 = 32'h3F800000; op_1 = 1'b1;
        sbq.push_back('{1'b0, 32'h3F800000, 1'b0});
        sbq.push_back('{1'b1, 32'h3F800000, 1'b0});
        wait_ack("rr_first", 30, lat, who, ok);
        chk32("rr_first_lat", 32'(lat), 32'd4);
        req_0 = 1'b0;
        wait_ack("rr_second", 30, lat, who, ok);
        chk32("rr_gap", 32'(lat), 32'd5);
        req_1 = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i]);
            tick();
        end

        // Reset while waiting on the unit: outputs clear at once, no ack later.
        um_dly = -1; um_keep = 1'b0;
        req_0 = 1'b1; dataa_0 = 32'h40E00000; datab_0 = 32'h40C00000; op_0 = 1'b1;
        t = 0;
        while (!unit_enable && t < 8) begin
            tick();
            t++;
        end
        tick();
        chk32("busy_before_reset", {31'd0, unit_enable}, 32'd1);
        #2;
        reset = 1'b1;
        req_0 = 1'b0;
        #1;
        chk32("arst_ack", {30'd0, ack_1, ack_0}, 32'd0);
        chk32("arst_result_0", result_0, 32'd0);
        chk32("arst_result_1", result_1, 32'd0);
        chk32("arst_err", {30'd0, err_1, err_0}, 32'd0);
        chk32("arst_enable", {31'd0, unit_enable}, 32'd0);
        chk32("arst_operands", unit_dataa | unit_datab, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        acks = 0;
        repeat (25) begin
            tick();
            if (ack_0 || ack_1) acks++;
        end
        chk32("no_ack_after_reset", 32'(acks), 32'd0);

        // req_1 held, req_0 toggling: grants alternate 0,1,0,1.
        um_dly = 0; um_keep = 1'b0; um_res = 32'h40A00000;
        req_0 = 1'b1; dataa_0 = 32'h40000000; datab_0 = 32'h40400000; op_0 = 1'b0;
        req_1 = 1'b1; dataa_1 = 32'h40800000; datab_1 = 32'hBF800000; op_1 = 1'b1;
        for (int k = 0; k < 4; k++) sbq.push_back('{k[0], 32'h40A00000, 1'b0});
        for (int k = 0; k < 4; k++) begin
            wait_ack("alternate", 30, lat, who, ok);
            if (k == 3) begin
                req_0 = 1'b0;
                req_1 = 1'b0;
            end else if (!who) begin
                req_0 = 1'b0;
                tick();
                tick();
                req_0 = 1'b1;
            end
        end
        repeat (3) tick();

        chk32("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
